// File: rtl/div_pkg.sv
// Shared types and corner-case resolution for the divide issue stage.
package div_pkg;

  localparam int DIV_W = 4;

  typedef struct packed {
    logic signed [DIV_W-1:0] dividend;
    logic signed [DIV_W-1:0] divisor;
  } op_t;

  typedef struct packed {
    logic signed [DIV_W-1:0] quotient;
    logic signed [DIV_W-1:0] remainder;
    logic                    div0;
    logic                    ovf;
  } res_t;

  // Divide-by-zero and most-negative / -1 are fixed up here so the raw
  // divider result is only ever used for ordinary operands.
  function automatic res_t resolve_div(input op_t op,
                                       input logic signed [DIV_W-1:0] raw_q,
                                       input logic signed [DIV_W-1:0] raw_r);
    res_t                    res;
    logic signed [DIV_W-1:0] min_val;
    min_val = {1'b1, {(DIV_W-1){1'b0}}};
    res     = '0;
    if (op.divisor == '0) begin
      res.quotient  = '0;
      res.remainder = op.dividend;
      res.div0      = 1'b1;
    end else if ((op.dividend == min_val) && (op.divisor == '1)) begin
      res.quotient  = min_val;
      res.remainder = '0;
      res.ovf       = 1'b1;
    end else begin
      res.quotient  = raw_q;
      res.remainder = raw_r;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_op_fifo.sv
// Small synchronous FIFO holding operand pairs ahead of the divider.
module div_op_fifo #(
  parameter int ENTRY_W = 8,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  // Storage needs no reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/divider.sv
// Combinational signed divider, truncating toward zero.
module divider #(
  parameter int W = 4
) (
  input  logic signed [W-1:0] dividend,
  input  logic signed [W-1:0] divisor,
  output logic signed [W-1:0] quotient,
  output logic signed [W-1:0] remainder
);

  // A zero divisor yields zeros so nothing undefined propagates downstream.
  always_comb begin
    quotient  = '0;
    remainder = '0;
    if (divisor != '0) begin
      quotient  = dividend / divisor;
      remainder = dividend % divisor;
    end
  end

endmodule

// File: rtl/div_issue_stage.sv
// Handshake wrapper: operand FIFO -> divider -> registered result with
// saturating div0/ovf statistics.  W must match div_pkg::DIV_W.
module div_issue_stage
  import div_pkg::*;
#(
  parameter int W     = DIV_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_dividend,
  input  logic [W-1:0]     in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_quotient,
  output logic [W-1:0]     out_remainder,
  output logic             out_div0,
  output logic             out_ovf,
  output logic [CNT_W-1:0] div0_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  op_t              in_op;
  op_t              head;
  res_t             res;
  logic signed [W-1:0] raw_q;
  logic signed [W-1:0] raw_r;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             load;
  logic             xfer;

  assign in_op.dividend = in_dividend;
  assign in_op.divisor  = in_divisor;

  // in_ready looks only at occupancy, never at a same-cycle pop.
  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  assign load     = ~fifo_empty & (~out_valid | out_ready);
  assign xfer     = out_valid & out_ready;

  div_op_fifo #(
    .ENTRY_W ($bits(op_t)),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_op),
    .pop   (load),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  divider #(
    .W (W)
  ) u_divider (
    .dividend  (head.dividend),
    .divisor   (head.divisor),
    .quotient  (raw_q),
    .remainder (raw_r)
  );

  assign res = resolve_div(head, raw_q, raw_r);

  // Result register: refills on load, empties only on a transfer without a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_div0      <= 1'b0;
      out_ovf       <= 1'b0;
    end else if (load) begin
      out_valid     <= 1'b1;
      out_quotient  <= res.quotient;
      out_remainder <= res.remainder;
      out_div0      <= res.div0;
      out_ovf       <= res.ovf;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

  // Statistics count delivered results only and stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      div0_cnt <= '0;
      ovf_cnt  <= '0;
    end else if (xfer) begin
      if (out_div0 && (div0_cnt != '1)) div0_cnt <= div0_cnt + CNT_W'(1);
      if (out_ovf  && (ovf_cnt  != '1)) ovf_cnt  <= ovf_cnt  + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_div_issue_stage.sv
// Directed bench for div_issue_stage: vector table plus multi-cycle sequences.
module tb_div_issue_stage;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_dividend;
  logic [W-1:0]     in_divisor;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_quotient;
  logic [W-1:0]     out_remainder;
  logic             out_div0;
  logic             out_ovf;
  logic [CNT_W-1:0] div0_cnt;
  logic [CNT_W-1:0] ovf_cnt;

  div_issue_stage #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_div0      (out_div0),
    .out_ovf       (out_ovf),
    .div0_cnt      (div0_cnt),
    .ovf_cnt       (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int d0;
    int ov;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   exp_div0 = 0;
  int   exp_ovf  = 0;
  vec_t vecs [12];
  vec_t hold [5];
  vec_t strm [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sv(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic drive(input vec_t v);
    in_valid    = 1'b1;
    in_dividend = W'(v.a);
    in_divisor  = W'(v.b);
  endtask

  task automatic run_one(input vec_t v, input string tag);
    int lat;
    out_ready = 1'b1;
    chk({tag, " in_ready"}, int'(in_ready), 1);
    drive(v);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, lat, 2);
    chk({tag, " q"}, sv(out_quotient), v.q);
    chk({tag, " r"}, sv(out_remainder), v.r);
    chk({tag, " div0"}, int'(out_div0), v.d0);
    chk({tag, " ovf"}, int'(out_ovf), v.ov);
    if (v.d0 != 0 && exp_div0 < 255) exp_div0++;
    if (v.ov != 0 && exp_ovf < 255) exp_ovf++;
    step();
    chk({tag, " drained"}, int'(out_valid), 0);
    chk({tag, " div0_cnt"}, int'(div0_cnt), exp_div0);
    chk({tag, " ovf_cnt"}, int'(ovf_cnt), exp_ovf);
  endtask

  initial begin
    int acc;
    int rcv;
    int first;
    int last;
    int held_q;
    int held_r;

    vecs[0]  = '{7, -3, -2, 1, 0, 0};
    vecs[1]  = '{-7, 3, -2, -1, 0, 0};
    vecs[2]  = '{5, 0, 0, 5, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 1, 0};
    vecs[4]  = '{-8, -1, -8, 0, 0, 1};
    vecs[5]  = '{-8, 1, -8, 0, 0, 0};
    vecs[6]  = '{6, 4, 1, 2, 0, 0};
    vecs[7]  = '{-7, -2, 3, -1, 0, 0};
    vecs[8]  = '{-8, 3, -2, -2, 0, 0};
    vecs[9]  = '{-1, 7, 0, -1, 0, 0};
    vecs[10] = '{7, -1, -7, 0, 0, 0};
    vecs[11] = '{-6, 0, 0, -6, 1, 0};

    hold[0] = '{7, 2, 3, 1, 0, 0};
    hold[1] = '{-7, 2, -3, -1, 0, 0};
    hold[2] = '{7, -4, -1, 3, 0, 0};
    hold[3] = '{3, 5, 0, 3, 0, 0};
    hold[4] = '{-5, -5, 1, 0, 0, 0};

    strm[0] = '{10 - 16, 2, -3, 0, 0, 0};
    strm[1] = '{5, 7, 0, 5, 0, 0};
    strm[2] = '{-6, -3, 2, 0, 0, 0};
    strm[3] = '{7, 7, 1, 0, 0, 0};

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("reset out_valid", int'(out_valid), 0);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset q", sv(out_quotient), 0);
    chk("reset div0_cnt", int'(div0_cnt), 0);
    chk("reset ovf_cnt", int'(ovf_cnt), 0);

    for (int i = 0; i < 12; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: one held result plus a full FIFO, then in-order drain.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      automatic logic ready_now = in_ready;
      drive(hold[(acc < 5) ? acc : 4]);
      step();
      if (ready_now) acc++;
    end
    in_valid = 1'b0;
    chk("bp accepted", acc, 5);
    chk("bp in_ready", int'(in_ready), 0);
    held_q = sv(out_quotient);
    held_r = sv(out_remainder);
    chk("bp held q", held_q, hold[0].q);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp stable valid", int'(out_valid), 1);
      chk("bp stable q", sv(out_quotient), held_q);
      chk("bp stable r", sv(out_remainder), held_r);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp drain%0d valid", k), int'(out_valid), 1);
      chk($sformatf("bp drain%0d q", k), sv(out_quotient), hold[k].q);
      chk($sformatf("bp drain%0d r", k), sv(out_remainder), hold[k].r);
      step();
    end
    chk("bp empty", int'(out_valid), 0);
    chk("bp in_ready after", int'(in_ready), 1);

    // Streaming: one result per cycle with no bubbles.
    rcv = 0;
    first = -1;
    last = -1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        if (rcv < 4) begin
          chk($sformatf("stream%0d q", rcv), sv(out_quotient), strm[rcv].q);
          chk($sformatf("stream%0d r", rcv), sv(out_remainder), strm[rcv].r);
          chk($sformatf("stream%0d flags", rcv), int'({out_div0, out_ovf}), 0);
        end
        if (rcv == 0) first = c;
        last = c;
        rcv++;
      end
      if (c < 4) drive(strm[c]);
      else in_valid = 1'b0;
      step();
    end
    chk("stream count", rcv, 4);
    chk("stream first cycle", first, 2);
    chk("stream last cycle", last, 5);

    // Saturation of the div0 counter under a long div0 stream.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_dividend = W'(1);
    in_divisor  = '0;
    for (int c = 0; c < 280; c++) step();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    exp_div0 = 255;
    chk("sat div0_cnt", int'(div0_cnt), exp_div0);
    chk("sat ovf_cnt", int'(ovf_cnt), exp_ovf);

    // Reset with results queued and held discards everything.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(hold[c]);
      step();
    end
    in_valid = 1'b0;
    chk("pre-rst out_valid", int'(out_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_div0 = 0;
    exp_ovf  = 0;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst div0_cnt", int'(div0_cnt), 0);
    chk("rst ovf_cnt", int'(ovf_cnt), 0);
    out_ready = 1'b1;
    step();
    chk("rst no stale output", int'(out_valid), 0);
    run_one(vecs[6], "post-rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
